fc_neuron_mac_lanes: RTL and testbench
======================================

// Module: fc_neuron_mac_lanes
// PURPOSE
// - Generalised fully-connected neuron: NUM_LANES inputs per beat, NUM_LANES parallel signed MACs.
// - Weights and bias are runtime-loaded over the shared config bus (layer/neuron match).
// - Uses a saturating accumulator, then bias add, then a ReLU stage.
// - Sits in a layer array. Consumes the previous layer's output vector through a valid/ready
//   stream and produces one activation per vector through a valid/ready output.
// PARAMETERS
// - LAYER_NO    1    config-bus layer id this neuron answers to
// - NEURON_NO   0    config-bus neuron id this neuron answers to
// - NUM_WEIGHT  784  weights per neuron; must be a multiple of NUM_LANES
// - NUM_LANES   4    inputs/products per beat; BEATS = NUM_WEIGHT/NUM_LANES
// - DW          16   data width of inputs, weights, bias and output
// - W_INT       1    weight integer bits; output slice = acc[2*DW-1-W_INT -: DW]
// - LEAK_SH     3    leaky-ReLU right shift (used only with macro)
// PORTS
// - clk          in   1            clock
// - rst          in   1            synchronous, active-high reset
// - in_data      in   NUM_LANES*DW lane i = bits [i*DW +: DW], signed
// - in_valid     in   1            input beat valid
// - in_ready     out  1            neuron accepts beat
// - cfg_w_valid  in   1            weight write strobe
// - cfg_b_valid  in   1            bias write strobe
// - cfg_value    in   32           weight/bias value, [DW-1:0] used
// - cfg_layer    in   32           config target layer
// - cfg_neuron   in   32           config target neuron
// - out_data     out  DW           activation, signed
// - out_valid    out  1            result valid, held until out_ready
// - out_ready    in   1            downstream accepts result
// - cfg_err      out  1            1-cycle pulse: weight write dropped (not IDLE)
// BEHAVIOUR
// - Reset values: in_ready=0 during rst and 1 the cycle after; out_valid=0; out_data=0; cfg_err=0.
//   Reset also clears state=IDLE, beat_cnt=0, wr_ptr=0, acc=0, bias_reg=0.
//   Weight RAM contents are preserved across reset.
// - Weight load accepts a write only in IDLE with layer/neuron match.
//   - Each write stores one weight into word wr_ptr/NUM_LANES, lane wr_ptr%NUM_LANES.
//   - wr_ptr wraps from NUM_WEIGHT-1 to 0.
//   - A matching write outside IDLE is dropped and pulses cfg_err.
// - Bias write (any state, on match): bias_reg<=cfg_value[DW-1:0].
//   Bias is aligned as sign-extended {bias_reg, DW'b0} with 2*DW bits; it takes effect at the next BIAS.
// - in_ready=1 in IDLE/ACCUM while beat_cnt<BEATS; 0 in DRAIN/BIAS/OUT.
//   A beat is accepted when in_valid&in_ready.
// - FSM:
//   - IDLE: first accepted beat -> ACCUM.
//   - ACCUM: last beat (beat_cnt==BEATS-1) accepted -> DRAIN.
//   - DRAIN: 4 cycles to flush the pipeline -> BIAS.
//   - BIAS: acc<=sat(acc+bias) -> OUT.
//   - OUT: out_valid=1 until out_ready -> IDLE with acc=0 and beat_cnt=0.
// - Pipeline:
//   - T: beat accepted, RAM read issued.
//   - T+1: weights and inputs registered.
//   - T+2: NUM_LANES products registered, 2*DW signed each.
//   - T+3: lane sum in 2*DW+clog2(NUM_LANES) bits, saturated to 2*DW.
//   - T+4: acc<=sat(acc+lanesum).
// - Latency: out_valid rises exactly 6 cycles after the last beat is accepted (no input bubbles needed).
// - Saturation rule for every add: pos+pos giving a negative result -> 0x7FFF..F; neg+neg giving a
//   non-negative result -> 0x8000..0.
// - Activation (registered in BIAS->OUT):
//   - acc<0 -> out_data=0.
//   - Otherwise out_data=slice; if the slice MSB or any discarded upper bit is set -> 0x7FFF.
// - out_data and out_valid are stable while out_valid&!out_ready.
//   in_valid is ignored during OUT, with no buffering.
// - rst mid-vector aborts the vector with no output; partial acc is discarded.
// CONFIGURATION
// - NEURON_LEAKY_RELU_EN defined:
//   - acc<0 -> out_data = (acc>>>LEAK_SH) sliced as above.
//   - Result saturates to 0x8000 if below range.
// - Undefined: plain ReLU as above; LEAK_SH unused.
// TESTING (DW=16, W_INT=1, NUM_LANES=4, NUM_WEIGHT=8, BEATS=2)
// - Load 8 weights 0x0100, bias 0; send 2 beats of all-0x0100
//   -> out_data=0x0010, out_valid 6 cycles after 2nd beat.
// - Same, bias 0x0001 -> acc 0x90000, out_data=0x0012.
// - Weights 0xFF00, inputs 0x0100, bias 0 -> out_data=0x0000; with NEURON_LEAKY_RELU_EN -> 0xFFFE.
// - Inputs and weights 0x7FFF -> acc clamps 0x7FFFFFFF, out_data=0x7FFF; second vector restarts from acc=0.
// - Hold out_ready=0 for 10 cycles with in_valid=1 -> out_data stable, in_ready=0;
//   weight write then -> cfg_err pulse, RAM unchanged.
// - Assert rst after beat 1 -> no out_valid; the following full vector gives the nominal result,
//   using the weights retained across reset.

Source files
------------

// File: rtl/fc_neuron_mac_lanes.sv
// fc_neuron_mac_lanes: NUM_LANES-wide saturating MAC neuron, runtime weights/bias, ReLU output.
// Define NEURON_LEAKY_RELU_EN for a leaky ReLU (negative accumulator shifted right by LEAK_SH).
module fc_neuron_mac_lanes #(
    parameter int LAYER_NO   = 1,
    parameter int NEURON_NO  = 0,
    parameter int NUM_WEIGHT = 784,
    parameter int NUM_LANES  = 4,
    parameter int DW         = 16,
    parameter int W_INT      = 1,
    parameter int LEAK_SH    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_LANES*DW-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    cfg_w_valid,
    input  logic                    cfg_b_valid,
    input  logic [31:0]             cfg_value,
    input  logic [31:0]             cfg_layer,
    input  logic [31:0]             cfg_neuron,
    output logic [DW-1:0]           out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    cfg_err
);
    localparam int BEATS = NUM_WEIGHT / NUM_LANES;
    localparam int AW    = 2 * DW;
    localparam int SW    = AW + $clog2(NUM_LANES);
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int LW    = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, OUT} state_t;

    state_t                 state, state_nx;
    logic [BW-1:0]          beat_cnt, wr_word;
    logic [LW-1:0]          wr_lane;
    logic [1:0]             dcnt;
    logic signed [AW-1:0]   acc, acc_b, lsum_q, lsum_sat;
    logic signed [SW-1:0]   lsum;
    logic [DW-1:0]          bias_reg, act;
    logic signed [DW-1:0]   wram [BEATS][NUM_LANES];
    logic signed [DW-1:0]   w_q [NUM_LANES];
    logic signed [DW-1:0]   x_q [NUM_LANES];
    logic signed [AW-1:0]   prod [NUM_LANES];
    logic                   v1, v2, v3, accept, last, match, wr_en, unused_bits;

    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a, input logic signed [AW-1:0] b);
        logic signed [AW-1:0] s;
        s = a + b;
        return (!a[AW-1] && !b[AW-1] && s[AW-1]) ? {1'b0, {(AW-1){1'b1}}}
             : (a[AW-1] && b[AW-1] && !s[AW-1]) ? {1'b1, {(AW-1){1'b0}}} : s;
    endfunction

    assign match  = cfg_layer == 32'(LAYER_NO) && cfg_neuron == 32'(NEURON_NO);
    assign wr_en  = cfg_w_valid && match && state == IDLE && !rst;
    assign accept = in_valid && in_ready;
    assign last   = beat_cnt == BW'(BEATS - 1);

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = last ? DRAIN : ACCUM;
            ACCUM:   if (accept && last) state_nx = DRAIN;
            DRAIN:   if (dcnt == 2'd3) state_nx = BIAS;
            BIAS:    state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && (state == IDLE || state == ACCUM);
        out_valid = state == OUT;
    end

    // Lane sum carries clog2(NUM_LANES) guard bits, then clamps back to 2*DW.
    always_comb begin
        lsum = '0;
        for (int i = 0; i < NUM_LANES; i++) lsum = lsum + SW'(prod[i]);
        lsum_sat = (&lsum[SW-1:AW-1] || ~|lsum[SW-1:AW-1]) ? lsum[AW-1:0]
                 : {lsum[SW-1], {(AW-1){~lsum[SW-1]}}};
    end

`ifdef NEURON_LEAKY_RELU_EN
    logic signed [AW-1:0] sh;
    always_comb begin
        acc_b = sat_add(acc, {bias_reg, {DW{1'b0}}});
        sh    = acc_b >>> LEAK_SH;
        act   = acc_b[AW-1] ? (&sh[AW-2 -: W_INT] ? sh[AW-1-W_INT -: DW] : {1'b1, {(DW-1){1'b0}}})
              : (|acc_b[AW-2 -: W_INT] ? {1'b0, {(DW-1){1'b1}}} : acc_b[AW-1-W_INT -: DW]);
    end
    assign unused_bits = ^{cfg_value[31:DW], sh[AW-1], sh[DW-W_INT-1:0]};
`else
    always_comb begin
        acc_b = sat_add(acc, {bias_reg, {DW{1'b0}}});
        act   = acc_b[AW-1] ? '0
              : (|acc_b[AW-2 -: W_INT] ? {1'b0, {(DW-1){1'b1}}} : acc_b[AW-1-W_INT -: DW]);
    end
    assign unused_bits = ^{cfg_value[31:DW], LEAK_SH[0]};
`endif

    // Weight RAM and MAC pipeline carry no reset; the valid chain qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) wram[wr_word][wr_lane] <= cfg_value[DW-1:0];
        for (int i = 0; i < NUM_LANES; i++) begin
            w_q[i]  <= wram[beat_cnt][i];
            x_q[i]  <= in_data[i*DW +: DW];
            prod[i] <= w_q[i] * x_q[i];
        end
        lsum_q <= lsum_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            dcnt     <= '0;
            wr_word  <= '0;
            wr_lane  <= '0;
            acc      <= '0;
            bias_reg <= '0;
            out_data <= '0;
            cfg_err  <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
        end else begin
            v1      <= accept;
            v2      <= v1;
            v3      <= v2;
            dcnt    <= state == DRAIN ? dcnt + 2'd1 : 2'd0;
            cfg_err <= cfg_w_valid && match && state != IDLE;
            if (accept && !last) beat_cnt <= beat_cnt + 1'b1;
            else if (state == OUT && out_ready) beat_cnt <= '0;
            if (state == BIAS) acc <= acc_b;
            else if (state == OUT && out_ready) acc <= '0;
            else if (v3) acc <= sat_add(acc, lsum_q);
            if (state == BIAS) out_data <= act;
            if (cfg_b_valid && match) bias_reg <= cfg_value[DW-1:0];
            if (wr_en) begin
                wr_lane <= wr_lane == LW'(NUM_LANES - 1) ? '0 : wr_lane + 1'b1;
                if (wr_lane == LW'(NUM_LANES - 1)) wr_word <= wr_word == BW'(BEATS - 1) ? '0 : wr_word + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fc_neuron_mac_lanes.sv
// tb_fc_neuron_mac_lanes: directed checks of the 4-lane, 8-weight neuron configuration.
module tb_fc_neuron_mac_lanes;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        cfg_w_valid = 1'b0;
    logic        cfg_b_valid = 1'b0;
    logic [31:0] cfg_value = '0;
    logic [31:0] cfg_layer = 32'd1;
    logic [31:0] cfg_neuron = 32'd0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        cfg_err;
    int          tests = 0;
    int          fails = 0;

    fc_neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(8), .NUM_LANES(4),
                          .DW(16), .W_INT(1), .LEAK_SH(3)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_w_valid(cfg_w_valid), .cfg_b_valid(cfg_b_valid), .cfg_value(cfg_value),
        .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [15:0] v);
        cfg_value = {16'h0, v};
        cfg_w_valid = 1'b1;
        tick();
        cfg_w_valid = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] v);
        for (int k = 0; k < 8; k++) write_w(v);
    endtask

    task automatic set_bias(input logic [15:0] v, input logic [31:0] layer);
        cfg_value = {16'h0, v};
        cfg_layer = layer;
        cfg_b_valid = 1'b1;
        tick();
        cfg_b_valid = 1'b0;
        cfg_layer = 32'd1;
    endtask

    // lat counts cycles after the cycle the last beat was accepted; 40 means timed out.
    task automatic send_beats(input logic [63:0] b0, input logic [63:0] b1, output int lat);
        for (int b = 0; b < 2; b++) begin
            int n = 0;
            in_data = b == 0 ? b0 : b1;
            in_valid = 1'b1;
            while (!in_ready && n < 50) begin tick(); n++; end
            tick();
        end
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin tick(); lat++; end
    endtask

    task automatic take(output logic [15:0] res);
        res = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input logic [63:0] b0, input logic [63:0] b1, output logic [15:0] res, output int lat);
        send_beats(b0, b1, lat);
        take(res);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        rst = 1'b0;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [15:0] r; int lat;
        load_all(16'h0100);
        set_bias(16'h0000, 32'd1);
        run_vec({4{16'h0100}}, {4{16'h0100}}, r, lat);
        tests++; if (lat !== 6) begin fails++; $display("FAIL basic_latency got=%0d exp=6", lat); end
        tests++; if (r !== 16'h0010) begin fails++; $display("FAIL basic_out got=%h exp=0010", r); end
    endtask

    task automatic test_bias();
        logic [15:0] r; int lat;
        set_bias(16'h0001, 32'd1);
        set_bias(16'h7000, 32'd2);
        run_vec({4{16'h0100}}, {4{16'h0100}}, r, lat);
        tests++; if (r !== 16'h0012) begin fails++; $display("FAIL bias_out got=%h exp=0012", r); end
    endtask

    task automatic test_negative();
        logic [15:0] r, e; int lat;
`ifdef NEURON_LEAKY_RELU_EN
        e = 16'hFFFE;
`else
        e = 16'h0000;
`endif
        load_all(16'hFF00);
        set_bias(16'h0000, 32'd1);
        run_vec({4{16'h0100}}, {4{16'h0100}}, r, lat);
        tests++; if (r !== e) begin fails++; $display("FAIL negative_out got=%h exp=%h", r, e); end
    endtask

    task automatic test_lanes();
        logic [15:0] r; int lat;
        for (int k = 0; k < 8; k++) write_w(16'((k + 1) * 256));
        run_vec({16'h0400, 16'h0300, 16'h0200, 16'h0100}, {16'h0, 16'h0, 16'h0, 16'h0100}, r, lat);
        tests++; if (r !== 16'h0046) begin fails++; $display("FAIL lane_map_out got=%h exp=0046", r); end
    endtask

    task automatic test_saturate();
        logic [15:0] r; int lat;
        load_all(16'h7FFF);
        run_vec({4{16'h7FFF}}, {4{16'h7FFF}}, r, lat);
        tests++; if (r !== 16'h7FFF) begin fails++; $display("FAIL saturate_out got=%h exp=7fff", r); end
        run_vec({4{16'h0100}}, {4{16'h0100}}, r, lat);
        tests++; if (r !== 16'h07FF) begin fails++; $display("FAIL restart_out got=%h exp=07ff", r); end
    endtask

    task automatic test_backpressure();
        logic [15:0] r; int lat;
        load_all(16'h0100);
        send_beats({4{16'h0100}}, {4{16'h0100}}, lat);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tests++;
            if (out_data !== 16'h0010 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_cycle%0d got data=%h valid=%b ready=%b exp 0010/1/0", c, out_data, out_valid, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        write_w(16'h7FFF);
        tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err); end
        tick();
        tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_err_end got=%b exp=0", cfg_err); end
        take(r);
        run_vec({4{16'h0100}}, {4{16'h0100}}, r, lat);
        tests++; if (r !== 16'h0010) begin fails++; $display("FAIL ram_unchanged_out got=%h exp=0010", r); end
    endtask

    task automatic test_reset_midvector();
        logic [15:0] r; int lat; int seen = 0;
        in_data = {4{16'h0100}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            tick();
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_output got=%0d valid cycles exp=0", seen); end
        run_vec({4{16'h0100}}, {4{16'h0100}}, r, lat);
        tests++; if (r !== 16'h0010) begin fails++; $display("FAIL after_abort_out got=%h exp=0010", r); end
        tests++; if (lat !== 6) begin fails++; $display("FAIL after_abort_latency got=%0d exp=6", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias();
        test_negative();
        test_lanes();
        test_saturate();
        test_backpressure();
        test_reset_midvector();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
